fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 171 +++++++++++++++++
 tb/tb_fetch_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Purpose:
//   Instruction fetch front end. It holds a program counter and presents it to
//   a combinational instruction memory. It also keeps a one-entry output slot
//   (instr / instr_pc / instr_valid) that a decode stage drains through a
//   valid/ready handshake. The block supports start, redirect (branch/jump
//   flush) and halt. With instr_ready held high it delivers one instruction
//   per cycle.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   begin fetching at start_addr (ignored while running)
//   start_addr     in   first fetch address
//   imem_addr      out  instruction-memory address (= PC register)
//   imem_instr     in   combinational read data from instruction memory
//   instr          out  registered instruction to decode
//   instr_pc       out  address of instr
//   instr_valid    out  instr / instr_pc hold a valid fetch
//   instr_ready    in   decode accepts instr this cycle
//   redirect       in   taken branch/jump: flush and refetch at redirect_addr
//   redirect_addr  in   branch target
//   halt           in   stop fetching (wins over redirect)
//   busy           out  high while fetching (RUN state)
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_count    out  32-bit count of output-slot loads
//   stall_count    out  32-bit count of RUN cycles with a held, unaccepted instr
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int unsigned ADDR_BUS_WIDTH    = 13,
  parameter int unsigned INSTRUCTION_WIDTH = 34
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_BUS_WIDTH-1:0]    start_addr,
  output logic [ADDR_BUS_WIDTH-1:0]    imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [ADDR_BUS_WIDTH-1:0]    instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [ADDR_BUS_WIDTH-1:0]    redirect_addr,
  input  logic                         halt,
  output logic                         busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  fetch_count,
  output logic [31:0]                  stall_count
`endif
);

  localparam int unsigned AW = ADDR_BUS_WIDTH;
  localparam int unsigned IW = INSTRUCTION_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]    state_q,       state_d;
  logic [AW-1:0] pc_q,          pc_d;
  logic [IW-1:0] instr_q,       instr_d;
  logic [AW-1:0] instr_pc_q,    instr_pc_d;
  logic          instr_valid_q, instr_valid_d;

  // The slot takes a new word only in RUN, when no halt or redirect is
  // present, and when the slot is empty or is being drained this cycle.
  logic load_c;
  assign load_c = (state_q == RUN) && !halt && !redirect &&
                  (!instr_valid_q || instr_ready);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = start_addr;
          instr_valid_d = 1'b0;
        end
      end

      RUN: begin
        // Halt dominates redirect. A word handshaken this same cycle counts
        // as consumed, so dropping the slot here never replays it.
        if (halt) begin
          state_d       = HALTED;
          instr_valid_d = 1'b0;
        end else if (redirect) begin
          pc_d          = redirect_addr;
          instr_valid_d = 1'b0;
        end else if (load_c) begin
          instr_d       = imem_instr;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          // Natural wrap modulo 2^AW
          pc_d          = AW'(pc_q + AW'(1));
        end
        // Otherwise the slot is stalled and everything holds
      end

      default: begin
        state_d       = IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q == RUN);

`ifdef FETCH_PERF_CNT_EN
  logic        stall_c;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  assign stall_c = (state_q == RUN) && instr_valid_q && !instr_ready;

  // Performance counters, wrapping at 2^32
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (load_c)  fetch_count_d = 32'(fetch_count_q + 32'd1);
    if (stall_c) stall_count_d = 32'(stall_count_q + 32'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Self-checking bench for fetch_controller. It runs directed scenarios and then
// a randomized phase. Every cycle is compared against a behavioural model that
// holds the PC as an integer and the output slot as a queue. Define
// FETCH_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int unsigned AW    = 13;
  localparam int unsigned IW    = 34;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, instr_ready, redirect, halt;
  logic [AW-1:0] start_addr, redirect_addr;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [IW-1:0] imem_instr, instr;
  logic          instr_valid, busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count, stall_count;
`endif

  logic [IW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_controller #(.ADDR_BUS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .busy          (busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model. The slot is a queue holding zero or one fetched word.
  typedef struct {
    logic [IW-1:0] word;
    int            pc;
  } fetch_t;

  bit          m_running;
  int          m_pc;
  fetch_t      m_slot[$];
  int unsigned m_fetches, m_stalls;
  bit          m_was_reset;

  function automatic void model_step(bit rs, bit st, int sa, bit rdy, bit rd, int ra, bit hl);
    fetch_t f;
    m_was_reset = rs;
    if (rs) begin
      m_running = 0; m_pc = 0; m_slot.delete(); m_fetches = 0; m_stalls = 0;
      return;
    end
    if (!m_running) begin
      if (st) begin m_running = 1; m_pc = sa; m_slot.delete(); end
      return;
    end
    if (m_slot.size() != 0 && !rdy) m_stalls++;
    // A word accepted by decode this cycle leaves the slot
    if (m_slot.size() != 0 && rdy) m_slot.delete();
    if (hl) begin
      m_running = 0; m_slot.delete();
    end else if (rd) begin
      m_pc = ra; m_slot.delete();
    end else if (m_slot.size() == 0) begin
      f.word = mem[m_pc];
      f.pc   = m_pc;
      m_slot.push_back(f);
      m_pc = (m_pc + 1) % DEPTH;
      m_fetches++;
    end
  endfunction

  task automatic compare_model();
    check("busy", 64'(busy), 64'(m_running));
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("instr_valid", 64'(instr_valid), 64'(m_slot.size() != 0));
    if (m_slot.size() != 0) begin
      check("instr", 64'(instr), 64'(m_slot[0].word));
      check("instr_pc", 64'(instr_pc), 64'(m_slot[0].pc));
    end
    if (m_was_reset) begin
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_instr_pc", 64'(instr_pc), 64'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 64'(fetch_count), 64'(m_fetches));
    check("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
  endtask

  // One clock: drive inputs, clock, advance the model, compare 1 time unit later
  task automatic step(bit rs, bit st, int sa, bit rdy, bit rd, int ra, bit hl);
    reset = rs; start = st; start_addr = AW'(sa); instr_ready = rdy;
    redirect = rd; redirect_addr = AW'(ra); halt = hl;
    @(posedge clk);
    #1;
    model_step(rs, st, sa, rdy, rd, ra, hl);
    compare_model();
  endtask

  task automatic idle_ready(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {IW'($urandom), IW'($urandom)} ^ IW'(i);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 77, 1, 1, 5, 1);

    // Start at 10, streaming A..D
    step(0, 1, 10, 1, 0, 0, 0);
    check("s10_c1_valid", 64'(instr_valid), 64'd0);
    idle_ready(1);
    check("s10_c2_valid", 64'(instr_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("s10_pc", 64'(instr_pc), 64'(10 + k));
      check("s10_instr", 64'(instr), 64'(mem[10 + k]));
      idle_ready(1);
    end

    // Start ignored while running
    step(0, 1, 500, 1, 0, 0, 0);
    check("start_in_run_pc", 64'(instr_pc), 64'd15);

    // Stall at pc 20
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 20, 1, 0, 0, 0);
    idle_ready(1);
    check("stall_first", 64'(instr_pc), 64'd20);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check("stall_pc", 64'(instr_pc), 64'd20);
      check("stall_addr", 64'(imem_addr), 64'd21);
    end
    idle_ready(1);
    check("stall_resume21", 64'(instr_pc), 64'd21);
    idle_ready(1);
    check("stall_resume22", 64'(instr_pc), 64'd22);

    // Redirect while instr_pc = 5
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 4, 1, 0, 0, 0);
    idle_ready(2);
    check("redir_pre", 64'(instr_pc), 64'd5);
    step(0, 0, 0, 1, 1, 100, 0);
    check("redir_valid0", 64'(instr_valid), 64'd0);
    idle_ready(1);
    check("redir_pc100", 64'(instr_pc), 64'd100);
    check("redir_instr", 64'(instr), 64'(mem[100]));

    // Address wrap
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 8190, 1, 0, 0, 0);
    idle_ready(1);
    check("wrap_8190", 64'(instr_pc), 64'd8190);
    idle_ready(1);
    check("wrap_8191", 64'(instr_pc), 64'd8191);
    idle_ready(1);
    check("wrap_0", 64'(instr_pc), 64'd0);
    idle_ready(1);
    check("wrap_1", 64'(instr_pc), 64'd1);

    // Halt and redirect together at pc 30
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 30, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 200, 1);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_valid", 64'(instr_valid), 64'd0);
    check("halt_pc", 64'(imem_addr), 64'd30);
    step(0, 0, 0, 1, 1, 300, 0);
    check("halted_redir_ignored", 64'(imem_addr), 64'd30);
    step(0, 1, 30, 1, 0, 0, 0);
    idle_ready(1);
    check("restart30_valid", 64'(instr_valid), 64'd1);
    check("restart30_instr", 64'(instr), 64'(mem[30]));

    // Reset mid-stall
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    idle_ready(2);
    check("rst_no_fetch", 64'(instr_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH - 1))
                                       : int'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
